// File: rtl/rob_dispatch_alloc_if.sv
// Decode/ROB-side bus of the dispatch allocator.
//   dec_*        : decode group offered this cycle and its accept (dec_ready)
//   retire_count : entries the ROB retires this cycle
//   flush        : discard every allocated entry
//   disp_*       : registered, compacted allocations towards the ROB
//   rob_*        : occupancy status; err_underflow is sticky
// master = decode/ROB environment, slave = allocator.
interface rob_dispatch_alloc_if #(
  parameter int NUM_ROB_ENTS   = 64,
  parameter int DISPATCH_WIDTH = 4,
  parameter int RETIRE_WIDTH   = 4
);
  localparam int IDX_BITS = $clog2(NUM_ROB_ENTS);
  localparam int RC_W     = $clog2(RETIRE_WIDTH) + 1;

  logic [DISPATCH_WIDTH-1:0]          dec_valid;
  logic [DISPATCH_WIDTH*5-1:0]        dec_dst_reg;
  logic                               dec_ready;
  logic [RC_W-1:0]                    retire_count;
  logic                               flush;
  logic [DISPATCH_WIDTH-1:0]          disp_valid;
  logic [DISPATCH_WIDTH*IDX_BITS-1:0] disp_rob_idx;
  logic [DISPATCH_WIDTH*5-1:0]        disp_dst_reg;
  logic [IDX_BITS:0]                  rob_count;
  logic                               rob_full;
  logic                               rob_empty;
  logic                               err_underflow;

  modport master (
    output dec_valid, dec_dst_reg, retire_count, flush,
    input  dec_ready, disp_valid, disp_rob_idx, disp_dst_reg,
           rob_count, rob_full, rob_empty, err_underflow
  );

  modport slave (
    input  dec_valid, dec_dst_reg, retire_count, flush,
    output dec_ready, disp_valid, disp_rob_idx, disp_dst_reg,
           rob_count, rob_full, rob_empty, err_underflow
  );
endinterface

// File: rtl/rob_dispatch_alloc.sv
// ROB dispatch allocator.
// Accepts a whole decode group when at least DISPATCH_WIDTH entries are free,
// compacts the valid slots towards output slot 0 and hands each one the next
// ROB index from tail. Tracks head/tail/occupancy against retires and flushes.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : rob_dispatch_alloc_if.slave (decode group, retire, flush, disp_*,
//          occupancy status, sticky underflow)

// One output slot: picks the SLOT-th valid input slot (ascending order).
module rob_disp_lane #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int IDX_BITS       = 6,
  parameter int SLOT           = 0
) (
  input  logic [DISPATCH_WIDTH-1:0]   valid,
  input  logic [DISPATCH_WIDTH*5-1:0] dst_flat,
  input  logic [IDX_BITS-1:0]         tail,
  output logic                        lane_valid,
  output logic [IDX_BITS-1:0]         lane_idx,
  output logic [4:0]                  lane_dst
);
  localparam int AC_W = $clog2(DISPATCH_WIDTH) + 1;
  localparam logic [AC_W-1:0] SLOT_C = AC_W'(SLOT);

  logic [AC_W-1:0] rank;

  always_comb begin
    rank     = '0;
    lane_dst = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (valid[i]) begin
        if (rank == SLOT_C) lane_dst = dst_flat[5*i +: 5];
        rank = rank + AC_W'(1);
      end
    end
    lane_valid = (rank > SLOT_C);
  end

  // Compacted slots take consecutive indices; truncation gives the wrap.
  assign lane_idx = tail + IDX_BITS'(SLOT);
endmodule

module rob_dispatch_alloc #(
  parameter int NUM_ROB_ENTS   = 64,
  parameter int DISPATCH_WIDTH = 4,
  parameter int RETIRE_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rob_dispatch_alloc_if.slave  bus
);
  localparam int IDX_BITS = $clog2(NUM_ROB_ENTS);
  localparam int CNT_W    = IDX_BITS + 1;
  localparam int AC_W     = $clog2(DISPATCH_WIDTH) + 1;
  localparam logic [CNT_W-1:0] ENTS_C = CNT_W'(NUM_ROB_ENTS);
  localparam logic [CNT_W-1:0] DW_C   = CNT_W'(DISPATCH_WIDTH);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t                                   state_q, state_d;
  logic [IDX_BITS-1:0]                      head_q, tail_q;
  logic [CNT_W-1:0]                         count_q;
  logic                                     err_q;
  logic [DISPATCH_WIDTH-1:0]                disp_valid_q;
  logic [DISPATCH_WIDTH-1:0][IDX_BITS-1:0]  disp_idx_q;
  logic [DISPATCH_WIDTH-1:0][4:0]           disp_dst_q;

  logic [DISPATCH_WIDTH-1:0]                lane_valid;
  logic [DISPATCH_WIDTH-1:0][IDX_BITS-1:0]  lane_idx;
  logic [DISPATCH_WIDTH-1:0][4:0]           lane_dst;

  logic                ready;
  logic                acc;
  logic [AC_W-1:0]     acc_cnt;
  logic [CNT_W-1:0]    acc_n;
  logic [CNT_W-1:0]    ret_ext;
  logic                underflow;
  logic [CNT_W-1:0]    eff_ret;
  logic [IDX_BITS-1:0] head_adv;

  // Next state and dec_ready. dec_ready looks only at registered state and
  // rst, never at dec_valid.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      RUN: begin
        ready = rst && ((ENTS_C - count_q) >= DW_C);
        if (bus.flush) state_d = RECOVER;
      end
      RECOVER: begin
        state_d = bus.flush ? RECOVER : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign acc = ready && (|bus.dec_valid) && !bus.flush;

  always_comb begin
    acc_cnt = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      acc_cnt = acc_cnt + AC_W'(bus.dec_valid[i]);
  end

  assign acc_n     = acc ? CNT_W'(acc_cnt) : '0;
  // Retire is clamped to occupancy; the excess is only reported.
  assign ret_ext   = CNT_W'(bus.retire_count);
  assign underflow = (ret_ext > count_q);
  assign eff_ret   = underflow ? count_q : ret_ext;
  assign head_adv  = head_q + eff_ret[IDX_BITS-1:0];

  for (genvar s = 0; s < DISPATCH_WIDTH; s++) begin : g_lane
    rob_disp_lane #(
      .DISPATCH_WIDTH (DISPATCH_WIDTH),
      .IDX_BITS       (IDX_BITS),
      .SLOT           (s)
    ) u_lane (
      .valid      (bus.dec_valid),
      .dst_flat   (bus.dec_dst_reg),
      .tail       (tail_q),
      .lane_valid (lane_valid[s]),
      .lane_idx   (lane_idx[s]),
      .lane_dst   (lane_dst[s])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      disp_valid_q <= '0;
      disp_idx_q   <= '0;
      disp_dst_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_adv;
      if (bus.flush) begin
        // Everything beyond the retiring entries is discarded: tail snaps
        // to the new head.
        tail_q  <= head_adv;
        count_q <= '0;
      end else begin
        tail_q  <= tail_q + acc_n[IDX_BITS-1:0];
        count_q <= count_q + acc_n - eff_ret;
      end
      if (underflow) err_q <= 1'b1;
      disp_valid_q <= acc ? lane_valid : '0;
      if (acc) begin
        disp_idx_q <= lane_idx;
        disp_dst_q <= lane_dst;
      end
    end
  end

  assign bus.dec_ready     = ready;
  assign bus.disp_valid    = disp_valid_q;
  assign bus.disp_rob_idx  = disp_idx_q;
  assign bus.disp_dst_reg  = disp_dst_q;
  assign bus.rob_count     = count_q;
  assign bus.rob_full      = (count_q == ENTS_C);
  assign bus.rob_empty     = (count_q == '0);
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_rob_dispatch_alloc.sv
module tb_rob_dispatch_alloc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rob_dispatch_alloc_if #(.NUM_ROB_ENTS(64), .DISPATCH_WIDTH(4), .RETIRE_WIDTH(4)) bus ();

  rob_dispatch_alloc #(.NUM_ROB_ENTS(64), .DISPATCH_WIDTH(4), .RETIRE_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [19:0] dst, input logic [2:0] rc,
                       input logic fl);
    bus.dec_valid    = v;
    bus.dec_dst_reg  = dst;
    bus.retire_count = rc;
    bus.flush        = fl;
  endtask

  task automatic test_reset();
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 3'd0, 1'b0);
    rst = 1'b0;
    tick(); tick();
    checks++; if (bus.dec_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", bus.dec_ready); end
    checks++; if (bus.rob_count !== 7'd0) begin failures++; $display("FAIL reset_count got %0d want 0", bus.rob_count); end
    checks++; if ({bus.rob_empty, bus.rob_full} !== 2'b10) begin failures++; $display("FAIL reset_empty_full got %b want 10", {bus.rob_empty, bus.rob_full}); end
    checks++; if ({bus.disp_valid, bus.err_underflow} !== 5'b0) begin failures++; $display("FAIL reset_disp_err got %b want 0", {bus.disp_valid, bus.err_underflow}); end
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %b want 1", bus.dec_ready); end
  endtask

  task automatic test_full_group();
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 3'd0, 1'b0);
    tick();
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    checks++; if (bus.disp_valid !== 4'b1111) begin failures++; $display("FAIL full_valid got %b want 1111", bus.disp_valid); end
    checks++; if (bus.disp_rob_idx !== {6'd3, 6'd2, 6'd1, 6'd0}) begin failures++; $display("FAIL full_idx got %h want %h", bus.disp_rob_idx, {6'd3, 6'd2, 6'd1, 6'd0}); end
    checks++; if (bus.disp_dst_reg !== {5'd4, 5'd3, 5'd2, 5'd1}) begin failures++; $display("FAIL full_dst got %h want %h", bus.disp_dst_reg, {5'd4, 5'd3, 5'd2, 5'd1}); end
    checks++; if (bus.rob_count !== 7'd4) begin failures++; $display("FAIL full_count got %0d want 4", bus.rob_count); end
    tick();
    checks++; if (bus.disp_valid !== 4'b0000) begin failures++; $display("FAIL idle_valid got %b want 0000", bus.disp_valid); end
  endtask

  task automatic test_sparse();
    drive(4'b1010, {5'd9, 5'd31, 5'd7, 5'd30}, 3'd0, 1'b0);
    tick();
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    checks++; if (bus.disp_valid !== 4'b0011) begin failures++; $display("FAIL sparse_valid got %b want 0011", bus.disp_valid); end
    checks++; if (bus.disp_rob_idx[11:0] !== {6'd5, 6'd4}) begin failures++; $display("FAIL sparse_idx got %h want %h", bus.disp_rob_idx[11:0], {6'd5, 6'd4}); end
    checks++; if (bus.disp_dst_reg[9:0] !== {5'd9, 5'd7}) begin failures++; $display("FAIL sparse_dst got %h want %h", bus.disp_dst_reg[9:0], {5'd9, 5'd7}); end
    checks++; if (bus.rob_count !== 7'd6) begin failures++; $display("FAIL sparse_count got %0d want 6", bus.rob_count); end
  endtask

  task automatic test_fill();
    // 6 -> 58 in groups of four, then three more -> 61 (tail 61, head 0)
    for (int g = 0; g < 13; g++) begin
      checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d got %b want 1", g, bus.dec_ready); end
      drive(4'b1111, 20'd0, 3'd0, 1'b0);
      tick();
    end
    drive(4'b0111, 20'd0, 3'd0, 1'b0);
    tick();
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    checks++; if (bus.rob_count !== 7'd61) begin failures++; $display("FAIL fill_count got %0d want 61", bus.rob_count); end
    checks++; if (bus.dec_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_61 got %b want 0", bus.dec_ready); end
    // Offered group while not ready is dropped entirely.
    drive(4'b1111, 20'd0, 3'd0, 1'b0);
    tick();
    checks++; if ({bus.disp_valid, bus.rob_count} !== {4'b0000, 7'd61}) begin failures++; $display("FAIL notready_drop got %b/%0d want 0000/61", bus.disp_valid, bus.rob_count); end
    drive(4'b0000, 20'd0, 3'd1, 1'b0);
    tick();
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    checks++; if (bus.rob_count !== 7'd60) begin failures++; $display("FAIL retire1_count got %0d want 60", bus.rob_count); end
    checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL retire1_ready got %b want 1", bus.dec_ready); end
  endtask

  task automatic test_wrap();
    // Allocate 1 and retire 4 together: count 57, tail 62, head 5.
    drive(4'b0001, {15'd0, 5'd11}, 3'd4, 1'b0);
    tick();
    checks++; if ({bus.disp_valid, bus.disp_rob_idx[5:0]} !== {4'b0001, 6'd61}) begin failures++; $display("FAIL alloc_retire_idx got %b/%0d want 0001/61", bus.disp_valid, bus.disp_rob_idx[5:0]); end
    checks++; if (bus.rob_count !== 7'd57) begin failures++; $display("FAIL alloc_retire_count got %0d want 57", bus.rob_count); end
    drive(4'b1111, {5'd15, 5'd14, 5'd13, 5'd12}, 3'd0, 1'b0);
    tick();
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    checks++; if (bus.disp_rob_idx !== {6'd1, 6'd0, 6'd63, 6'd62}) begin failures++; $display("FAIL wrap_idx got %h want %h", bus.disp_rob_idx, {6'd1, 6'd0, 6'd63, 6'd62}); end
    checks++; if (bus.rob_count !== 7'd61) begin failures++; $display("FAIL wrap_count got %0d want 61", bus.rob_count); end
  endtask

  task automatic test_flush();
    // 61 -> 10 by retiring 51: head 56, tail 2.
    for (int r = 0; r < 12; r++) begin
      drive(4'b0000, 20'd0, 3'd4, 1'b0);
      tick();
    end
    drive(4'b0000, 20'd0, 3'd3, 1'b0);
    tick();
    checks++; if (bus.rob_count !== 7'd10) begin failures++; $display("FAIL preflush_count got %0d want 10", bus.rob_count); end
    drive(4'b1111, 20'd0, 3'd2, 1'b1);
    tick();
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    checks++; if ({bus.disp_valid, bus.rob_count} !== {4'b0000, 7'd0}) begin failures++; $display("FAIL flush_state got %b/%0d want 0000/0", bus.disp_valid, bus.rob_count); end
    checks++; if (bus.dec_ready !== 1'b0) begin failures++; $display("FAIL recover_ready got %b want 0", bus.dec_ready); end
    tick();
    checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL after_recover_ready got %b want 1", bus.dec_ready); end
    // Next allocation starts at old_head+2 = 58.
    drive(4'b0011, {10'd0, 5'd6, 5'd5}, 3'd0, 1'b0);
    tick();
    checks++; if ({bus.disp_valid, bus.disp_rob_idx[11:0]} !== {4'b0011, 6'd59, 6'd58}) begin failures++; $display("FAIL postflush_idx got %b/%h want 0011/%h", bus.disp_valid, bus.disp_rob_idx[11:0], {6'd59, 6'd58}); end
    // Back-to-back flush keeps RECOVER one more cycle.
    drive(4'b0000, 20'd0, 3'd0, 1'b1);
    tick();
    tick();
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    checks++; if (bus.dec_ready !== 1'b0) begin failures++; $display("FAIL double_flush_ready got %b want 0", bus.dec_ready); end
    tick();
    checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL double_flush_exit got %b want 1", bus.dec_ready); end
  endtask

  task automatic test_underflow();
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("FAIL err_clear got %b want 0", bus.err_underflow); end
    drive(4'b0001, {15'd0, 5'd20}, 3'd0, 1'b0);
    tick();
    checks++; if ({bus.disp_rob_idx[5:0], bus.rob_count} !== {6'd58, 7'd1}) begin failures++; $display("FAIL uf_setup got %0d/%0d want 58/1", bus.disp_rob_idx[5:0], bus.rob_count); end
    drive(4'b0000, 20'd0, 3'd3, 1'b0);
    tick();
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    checks++; if ({bus.rob_count, bus.err_underflow} !== {7'd0, 1'b1}) begin failures++; $display("FAIL underflow got %0d/%b want 0/1", bus.rob_count, bus.err_underflow); end
    tick(); tick();
    checks++; if (bus.err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got %b want 1", bus.err_underflow); end
  endtask

  task automatic test_reset_midop();
    drive(4'b0011, 20'd0, 3'd0, 1'b0);
    tick();
    drive(4'b1111, 20'd0, 3'd0, 1'b0);
    rst = 1'b0;
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready got %b want 0", bus.dec_ready); end
    tick();
    checks++; if ({bus.disp_valid, bus.rob_count, bus.err_underflow} !== {4'b0000, 7'd0, 1'b0}) begin failures++; $display("FAIL midreset_state got %b/%0d/%b want 0000/0/0", bus.disp_valid, bus.rob_count, bus.err_underflow); end
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    rst = 1'b1;
    drive(4'b0001, {15'd0, 5'd3}, 3'd0, 1'b0);
    tick();
    checks++; if ({bus.disp_valid, bus.disp_rob_idx[5:0]} !== {4'b0001, 6'd0}) begin failures++; $display("FAIL postreset_idx got %b/%0d want 0001/0", bus.disp_valid, bus.disp_rob_idx[5:0]); end
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
  endtask

  initial begin
    drive(4'b0000, 20'd0, 3'd0, 1'b0);
    test_reset();
    test_full_group();
    test_sparse();
    test_fill();
    test_wrap();
    test_flush();
    test_underflow();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rob_dispatch_alloc.md
ROB_DISPATCH_ALLOC -- requirements
Module: rob_dispatch_alloc

Interface
REQ-001 Parameter NUM_ROB_ENTS, default 64, SHALL give the ROB depth in entries; power of two.
REQ-002 Parameter DISPATCH_WIDTH, default 4, SHALL give the instruction slots offered per cycle.
REQ-003 Parameter RETIRE_WIDTH, default 4, SHALL give the maximum entries retired per cycle.
REQ-004 Localparam IDX_BITS = $clog2(NUM_ROB_ENTS) SHALL be used for ROB indices.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 dec_valid  in  DISPATCH_WIDTH  per-slot valid from decode; any bit pattern is legal.
REQ-008 dec_dst_reg  in  DISPATCH_WIDTH*5  per-slot architectural destination register; slot i occupies bits [5i+4:5i].
REQ-009 dec_ready  out  1  the whole decode group is accepted this cycle.
REQ-010 retire_count  in  $clog2(RETIRE_WIDTH)+1  number of entries the ROB retires this cycle.
REQ-011 flush  in  1  discard all allocated entries.
REQ-012 disp_valid  out  DISPATCH_WIDTH  registered per-slot allocation valid to the ROB, packed from slot 0.
REQ-013 disp_rob_idx  out  DISPATCH_WIDTH*IDX_BITS  allocated ROB index per output slot.
REQ-014 disp_dst_reg  out  DISPATCH_WIDTH*5  destination register per output slot.
REQ-015 rob_count  out  IDX_BITS+1  registered occupancy.
REQ-016 rob_full / rob_empty  out  1 each  rob_count==NUM_ROB_ENTS / rob_count==0.
REQ-017 err_underflow  out  1  sticky flag set when retire_count exceeds occupancy.

Function
REQ-018 The FSM SHALL have two states: RUN and RECOVER.
REQ-019 dec_ready SHALL be 1 only when state==RUN, rst==1, and (NUM_ROB_ENTS - rob_count) >= DISPATCH_WIDTH.
REQ-020 dec_ready SHALL depend only on registered state; there SHALL be no path from dec_valid.
REQ-021 Acceptance = dec_ready & |dec_valid & !flush; acceptance SHALL be all-or-nothing for the group.
REQ-022 On acceptance, valid slots SHALL be compacted in ascending slot order, and the k-th valid slot SHALL receive index (tail+k) mod NUM_ROB_ENTS.
REQ-023 Allocations SHALL appear on disp_* exactly one cycle after acceptance; disp_valid SHALL equal the popcount of dec_valid, packed from bit 0.
REQ-024 In cycles with no acceptance, disp_valid SHALL be 0 on the next cycle; disp_rob_idx and disp_dst_reg SHALL then be don't-care.
REQ-025 tail SHALL advance by the accepted count, modulo NUM_ROB_ENTS.
REQ-026 head SHALL advance by the effective retire amount, modulo NUM_ROB_ENTS.
REQ-027 rob_count next value SHALL be rob_count + accepted - effective retire; allocation and retire in the same cycle SHALL both apply.
REQ-028 Effective retire SHALL be min(retire_count, rob_count).
REQ-029 If retire_count > rob_count, err_underflow SHALL set and remain set until reset.
REQ-030 flush in RUN SHALL do all of the following:
- set head and tail to head + effective retire;
- set rob_count to 0;
- accept nothing that cycle;
- clear disp_valid on the next cycle;
- move the FSM to RECOVER.
REQ-031 RECOVER SHALL last exactly one cycle with dec_ready=0, then return to RUN; a flush while in RECOVER SHALL keep the FSM in RECOVER for one more cycle.
REQ-032 Retires during RECOVER SHALL be counted as underflow if they exceed occupancy; occupancy is 0 in RECOVER.
REQ-033 Pointer wrap SHALL be seamless: a group straddling index NUM_ROB_ENTS-1 SHALL continue from index 0.

Reset
REQ-034 While rst==0 at a clock edge, all of the following SHALL hold:
- head, tail and rob_count SHALL be 0;
- the FSM SHALL be in RUN;
- disp_valid and err_underflow SHALL be 0.
REQ-035 After reset, rob_empty SHALL be 1 and rob_full SHALL be 0.
REQ-036 dec_ready SHALL be forced to 0 while rst==0, including reset asserted mid-operation; any in-flight allocation SHALL be discarded.
REQ-037 Reset SHALL take priority over flush and acceptance.

Verification
REQ-038 Reset, then dec_valid=4'b1111 with dst 1,2,3,4 -> next cycle disp_valid=4'b1111, idx 0,1,2,3, dst 1..4, rob_count=4.
REQ-039 dec_valid=4'b1010 (dst slot1=7, slot3=9) at tail=4 -> disp_valid=4'b0011, idx 4,5, dst 7,9.
REQ-040 Fill to rob_count=61 -> dec_ready=0; then retire_count=1 -> rob_count=60 and dec_ready=1 on the following cycle.
REQ-041 Set tail=62 via allocation and retirement, then accept 4 -> idx 62,63,0,1, tail=2.
REQ-042 rob_count=10 with flush and retire_count=2 in the same cycle -> rob_count=0, head=tail=old_head+2, dec_ready=0 for one cycle, then 1.
REQ-043 rob_count=1 with retire_count=3 -> rob_count=0, err_underflow=1, and err_underflow stays 1 until rst=0.
